// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS front end: instruction field
// layout, opcode/funct/regimm encodings and the PC controller state type.
package pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned FUNCT_W = 6;

    // Primary opcodes
    localparam logic [OPC_W-1:0] OP_SPECIAL = 6'b000000;
    localparam logic [OPC_W-1:0] OP_REGIMM  = 6'b000001;
    localparam logic [OPC_W-1:0] OP_J       = 6'b000010;
    localparam logic [OPC_W-1:0] OP_JAL     = 6'b000011;
    localparam logic [OPC_W-1:0] OP_BEQ     = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE     = 6'b000101;
    localparam logic [OPC_W-1:0] OP_BLEZ    = 6'b000110;
    localparam logic [OPC_W-1:0] OP_BGTZ    = 6'b000111;

    // SPECIAL funct codes
    localparam logic [FUNCT_W-1:0] FN_JR   = 6'b001000;
    localparam logic [FUNCT_W-1:0] FN_JALR = 6'b001001;

    // REGIMM rt-field codes
    localparam logic [REG_W-1:0] RI_BLTZ   = 5'b00000;
    localparam logic [REG_W-1:0] RI_BGEZ   = 5'b00001;
    localparam logic [REG_W-1:0] RI_BLTZAL = 5'b10000;
    localparam logic [REG_W-1:0] RI_BGEZAL = 5'b10001;

    // I-type view of an instruction word
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [IMM_W-1:0] imm;
    } instr_i_t;

    typedef enum logic {PC_RUN, PC_HALT} pc_state_t;

endpackage

// File: rtl/pipe_pc_ctrl_if.sv
// Fetch-control bus between the core (master) and the PC controller (slave).
// Inputs to the controller: stall/enable, ID instruction, forwarded operands,
// external redirect. Outputs: fetch address/valid, halt, exception, stats.
interface pipe_pc_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
);
    import pipe_pkg::*;

    logic                 waitrequest;
    logic                 pc_write;
    logic [INSTR_W-1:0]   id_instr;
    logic [ADDR_W-1:0]    rs_val;
    logic [ADDR_W-1:0]    rt_val;
    logic                 ext_redirect_valid;
    logic [ADDR_W-1:0]    ext_redirect_addr;

    logic [ADDR_W-1:0]    pc;
    logic                 pc_valid;
    logic                 halted;
    logic                 exc_valid;
    logic [ADDR_W-1:0]    exc_badvaddr;
    logic [ADDR_W-1:0]    exc_epc;
    logic [CNT_W-1:0]     cnt_branch;
    logic [CNT_W-1:0]     cnt_taken;

    modport master (
        output waitrequest, pc_write, id_instr, rs_val, rt_val,
               ext_redirect_valid, ext_redirect_addr,
        input  pc, pc_valid, halted, exc_valid, exc_badvaddr, exc_epc,
               cnt_branch, cnt_taken
    );

    modport slave (
        input  waitrequest, pc_write, id_instr, rs_val, rt_val,
               ext_redirect_valid, ext_redirect_addr,
        output pc, pc_valid, halted, exc_valid, exc_badvaddr, exc_epc,
               cnt_branch, cnt_taken
    );

endinterface

// File: rtl/pipe_branch_resolve.sv
// Combinational ID-stage control-flow resolution.
// Ports: instr_i (IF/ID word), pc_i (delay-slot address), rs_val_i/rt_val_i
// (forwarded operands); is_branch_c_o (conditional branch), taken_c_o,
// misalign_c_o (JR/JALR to unaligned address), target_c_o (next sequential
// or control-flow target, excluding the exception vector).
module pipe_branch_resolve
    import pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [ADDR_W-1:0]  rs_val_i,
    input  logic [ADDR_W-1:0]  rt_val_i,
    output logic               is_branch_c_o,
    output logic               taken_c_o,
    output logic               misalign_c_o,
    output logic [ADDR_W-1:0]  target_c_o
);

    instr_i_t            f;
    logic [ADDR_W-1:0]   pc4;
    logic [ADDR_W-1:0]   br_tgt;
    logic [ADDR_W-1:0]   j_tgt;
    logic signed [IMM_W+1:0] br_off;
    logic                rs_neg;
    logic                rs_zero;
    logic                cond;
    logic                is_j;
    logic                is_jr;

    assign f       = instr_i;
    assign pc4     = pc_i + ADDR_W'(4);
    assign br_off  = {f.imm, 2'b00};
    // Signed cast sign-extends the word offset to the full address width
    assign br_tgt  = pc_i + ADDR_W'(br_off);
    // J/JAL index spans the rs, rt and imm fields
    assign j_tgt   = {pc4[ADDR_W-1:28], f.rs, f.rt, f.imm, 2'b00};
    assign rs_neg  = rs_val_i[ADDR_W-1];
    assign rs_zero = (rs_val_i == '0);

    // Opcode decode and condition evaluation
    always_comb begin
        is_branch_c_o = 1'b0;
        cond          = 1'b0;
        is_j          = 1'b0;
        is_jr         = 1'b0;
        unique case (f.opcode)
            OP_BEQ:  begin is_branch_c_o = 1'b1; cond = (rs_val_i == rt_val_i); end
            OP_BNE:  begin is_branch_c_o = 1'b1; cond = (rs_val_i != rt_val_i); end
            OP_BLEZ: begin is_branch_c_o = 1'b1; cond = rs_neg | rs_zero;        end
            OP_BGTZ: begin is_branch_c_o = 1'b1; cond = ~rs_neg & ~rs_zero;      end
            OP_REGIMM: begin
                if (f.rt == RI_BLTZ || f.rt == RI_BLTZAL) begin
                    is_branch_c_o = 1'b1;
                    cond          = rs_neg;
                end else if (f.rt == RI_BGEZ || f.rt == RI_BGEZAL) begin
                    is_branch_c_o = 1'b1;
                    cond          = ~rs_neg;
                end
            end
            OP_J, OP_JAL: is_j = 1'b1;
            OP_SPECIAL: begin
                if (f.imm[FUNCT_W-1:0] == FN_JR || f.imm[FUNCT_W-1:0] == FN_JALR) begin
                    is_jr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign taken_c_o    = is_branch_c_o & cond;
    assign misalign_c_o = is_jr & (rs_val_i[1:0] != 2'b00);

    // Target selection; branch/jump/jr are mutually exclusive by opcode
    always_comb begin
        target_c_o = pc4;
        if (taken_c_o) begin
            target_c_o = br_tgt;
        end else if (is_j) begin
            target_c_o = j_tgt;
        end else if (is_jr) begin
            target_c_o = rs_val_i;
        end
    end

endmodule

// File: rtl/pipe_pc_ctrl.sv
// Program-counter controller: holds the fetch PC, applies ID-stage
// branch/jump decisions, buffers external redirects across memory stalls,
// raises a precise exception on misaligned JR/JALR, halts at HALT_ADDR and
// counts resolved/taken conditional branches.
// Ports: clk, reset_n (async active-low), bus (slave side of pipe_pc_ctrl_if).
module pipe_pc_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned      ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC00000),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'hBFC00380),
    parameter logic [ADDR_W-1:0] HALT_ADDR    = '0,
    parameter int unsigned      CNT_W        = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    pipe_pc_ctrl_if.slave bus
);

    pc_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                exc_valid_q, exc_valid_d;
    logic [ADDR_W-1:0]   badv_q, badv_d;
    logic [ADDR_W-1:0]   epc_q, epc_d;
    logic [CNT_W-1:0]    cnt_br_q, cnt_br_d;
    logic [CNT_W-1:0]    cnt_tk_q, cnt_tk_d;

    logic                is_branch_c;
    logic                taken_c;
    logic                misalign_c;
    logic [ADDR_W-1:0]   target_c;

    pipe_branch_resolve #(.ADDR_W(ADDR_W)) u_resolve (
        .instr_i       (bus.id_instr),
        .pc_i          (pc_q),
        .rs_val_i      (bus.rs_val),
        .rt_val_i      (bus.rt_val),
        .is_branch_c_o (is_branch_c),
        .taken_c_o     (taken_c),
        .misalign_c_o  (misalign_c),
        .target_c_o    (target_c)
    );

    // Next-state, PC selection, redirect buffer, exception and counters
    always_comb begin
        logic              redir;
        logic              step;
        logic [ADDR_W-1:0] npc;

        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        exc_valid_d = 1'b0;
        badv_d      = badv_q;
        epc_d       = epc_q;
        cnt_br_d    = cnt_br_q;
        cnt_tk_d    = cnt_tk_q;
        npc         = pc_q;

        redir = bus.ext_redirect_valid | pend_q;
        step  = bus.pc_write & (state_q == PC_RUN);

        if (bus.waitrequest) begin
            // Stalled: only the redirect buffer moves; newest request wins
            if (bus.ext_redirect_valid) begin
                pend_d      = 1'b1;
                pend_addr_d = bus.ext_redirect_addr;
            end
        end else begin
            if (redir) begin
                // A live request is newer than the buffered one
                npc    = bus.ext_redirect_valid ? bus.ext_redirect_addr : pend_addr_q;
                pend_d = 1'b0;
            end else if (step) begin
                if (misalign_c) begin
                    npc         = EXC_VECTOR;
                    exc_valid_d = 1'b1;
                    badv_d      = bus.rs_val;
                    epc_d       = pc_q - ADDR_W'(4);
                end else begin
                    npc = target_c;
                end
            end
            if (redir || step) begin
                pc_d    = npc;
                state_d = (npc == HALT_ADDR) ? PC_HALT : PC_RUN;
            end
            if (step && is_branch_c) begin
                cnt_br_d = cnt_br_q + CNT_W'(1);
                if (taken_c) begin
                    cnt_tk_d = cnt_tk_q + CNT_W'(1);
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PC_RUN;
            pc_q        <= RESET_VECTOR;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            exc_valid_q <= 1'b0;
            badv_q      <= '0;
            epc_q       <= '0;
            cnt_br_q    <= '0;
            cnt_tk_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            exc_valid_q <= exc_valid_d;
            badv_q      <= badv_d;
            epc_q       <= epc_d;
            cnt_br_q    <= cnt_br_d;
            cnt_tk_q    <= cnt_tk_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_valid     = (state_q == PC_RUN);
    assign bus.halted       = (state_q == PC_HALT);
    assign bus.exc_valid    = exc_valid_q;
    assign bus.exc_badvaddr = badv_q;
    assign bus.exc_epc      = epc_q;
    assign bus.cnt_branch   = cnt_br_q;
    assign bus.cnt_taken    = cnt_tk_q;

endmodule

// File: tb/tb_pipe_pc_ctrl.sv
// Self-checking bench for pipe_pc_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipe_pc_ctrl;

    localparam logic [31:0] RV   = 32'hBFC00000;
    localparam logic [31:0] EV   = 32'hBFC00380;
    localparam logic [31:0] HALT = 32'h0;
    localparam logic [31:0] NOP  = 32'h0;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;

    pipe_pc_ctrl_if #(.ADDR_W(32), .CNT_W(32)) bus ();

    pipe_pc_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference state
    logic [31:0] m_pc, m_paddr, m_badv, m_epc, m_cb, m_ct;
    logic        m_halt, m_pend, m_exc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instruction semantics written directly in arithmetic
    always @(posedge clk or negedge reset_n) begin : model
        logic [31:0] npc, rs, rt;
        logic [5:0]  op, fn;
        logic [4:0]  rtf;
        logic        is_br, tk, was_run;
        int          off;
        if (!reset_n) begin
            m_pc <= RV; m_halt <= 1'b0; m_pend <= 1'b0; m_paddr <= '0;
            m_exc <= 1'b0; m_badv <= '0; m_epc <= '0; m_cb <= '0; m_ct <= '0;
        end else begin
            rs = bus.rs_val; rt = bus.rt_val;
            op = bus.id_instr[31:26]; fn = bus.id_instr[5:0]; rtf = bus.id_instr[20:16];
            was_run = !m_halt;
            m_exc <= 1'b0;
            if (bus.waitrequest) begin
                if (bus.ext_redirect_valid) begin
                    m_pend  <= 1'b1;
                    m_paddr <= bus.ext_redirect_addr;
                end
            end else begin
                is_br = 1'b0; tk = 1'b0;
                if (bus.ext_redirect_valid || m_pend) begin
                    npc = bus.ext_redirect_valid ? bus.ext_redirect_addr : m_paddr;
                    m_pend <= 1'b0;
                    m_pc   <= npc;
                    m_halt <= (npc == HALT);
                end else if (was_run && bus.pc_write) begin
                    npc = m_pc + 4;
                    case (op)
                        6'd4: begin is_br = 1'b1; tk = (rs == rt); end
                        6'd5: begin is_br = 1'b1; tk = (rs != rt); end
                        6'd6: begin is_br = 1'b1; tk = ($signed(rs) <= 0); end
                        6'd7: begin is_br = 1'b1; tk = ($signed(rs) > 0); end
                        6'd1: begin
                            if (rtf == 5'd0 || rtf == 5'd16) begin is_br = 1'b1; tk = ($signed(rs) < 0); end
                            if (rtf == 5'd1 || rtf == 5'd17) begin is_br = 1'b1; tk = ($signed(rs) >= 0); end
                        end
                        6'd2, 6'd3: npc = ((m_pc + 4) & 32'hF000_0000) | (32'(bus.id_instr[25:0]) * 4);
                        6'd0: begin
                            if (fn == 6'd8 || fn == 6'd9) begin
                                if (rs % 4 != 0) begin
                                    npc = EV;
                                    m_exc  <= 1'b1;
                                    m_badv <= rs;
                                    m_epc  <= m_pc - 4;
                                end else begin
                                    npc = rs;
                                end
                            end
                        end
                        default: ;
                    endcase
                    if (tk) begin
                        off = $signed(bus.id_instr[15:0]);
                        npc = m_pc + 32'(off * 4);
                    end
                    m_pc   <= npc;
                    m_halt <= (npc == HALT);
                end
                if (was_run && bus.pc_write && !(bus.ext_redirect_valid || m_pend) && 1'b0) begin
                end
                // Re-evaluate branch class even when a redirect overrides the target
                if (was_run && bus.pc_write) begin
                    is_br = 1'b0; tk = 1'b0;
                    case (op)
                        6'd4: begin is_br = 1'b1; tk = (rs == rt); end
                        6'd5: begin is_br = 1'b1; tk = (rs != rt); end
                        6'd6: begin is_br = 1'b1; tk = ($signed(rs) <= 0); end
                        6'd7: begin is_br = 1'b1; tk = ($signed(rs) > 0); end
                        6'd1: begin
                            if (rtf == 5'd0 || rtf == 5'd16) begin is_br = 1'b1; tk = ($signed(rs) < 0); end
                            if (rtf == 5'd1 || rtf == 5'd17) begin is_br = 1'b1; tk = ($signed(rs) >= 0); end
                        end
                        default: ;
                    endcase
                    if (is_br) begin
                        m_cb <= m_cb + 1;
                        if (tk) m_ct <= m_ct + 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("pc",           64'(bus.pc),           64'(m_pc));
        chk("pc_valid",     64'(bus.pc_valid),     64'(!m_halt));
        chk("halted",       64'(bus.halted),       64'(m_halt));
        chk("exc_valid",    64'(bus.exc_valid),    64'(m_exc));
        chk("exc_badvaddr", 64'(bus.exc_badvaddr), 64'(m_badv));
        chk("exc_epc",      64'(bus.exc_epc),      64'(m_epc));
        chk("cnt_branch",   64'(bus.cnt_branch),   64'(m_cb));
        chk("cnt_taken",    64'(bus.cnt_taken),    64'(m_ct));
    end

    // One clock of stimulus; entered and left at posedge+1
    task automatic cyc(input logic w, input logic pw, input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic rv, input logic [31:0] ra);
        bus.waitrequest        = w;
        bus.pc_write           = pw;
        bus.id_instr           = ins;
        bus.rs_val             = rs;
        bus.rt_val             = rt;
        bus.ext_redirect_valid = rv;
        bus.ext_redirect_addr  = ra;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = 32'h0;
            1: v = 32'h8000_0000 | 32'($urandom_range(0, 255));
            2: v = 32'($urandom_range(1, 255));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [4:0]  ri;
        logic [15:0] imm;
        logic [4:0]  rtsel [5];
        logic [31:0] w;
        rtsel[0] = 5'd0; rtsel[1] = 5'd1; rtsel[2] = 5'd16; rtsel[3] = 5'd17; rtsel[4] = 5'd5;
        imm = 16'($urandom);
        ri  = rtsel[$urandom_range(0, 4)];
        case ($urandom_range(0, 10))
            0:  w = NOP;
            1:  w = {6'd4, 5'd1, 5'd2, imm};
            2:  w = {6'd5, 5'd1, 5'd2, imm};
            3:  w = {6'd6, 5'd1, 5'd0, imm};
            4:  w = {6'd7, 5'd1, 5'd0, imm};
            5:  w = {6'd1, 5'd1, ri, imm};
            6:  w = {6'd2, 26'($urandom)};
            7:  w = {6'd3, 26'($urandom)};
            8:  w = {6'd0, 5'd3, 15'd0, 6'd8};
            9:  w = {6'd0, 5'd3, 15'd0, 6'd9};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] rs, rt, ra;
        n_chk = 0;
        n_err = 0;
        reset_n = 1'b0;
        bus.waitrequest = 1'b0; bus.pc_write = 1'b0; bus.id_instr = NOP;
        bus.rs_val = '0; bus.rt_val = '0;
        bus.ext_redirect_valid = 1'b0; bus.ext_redirect_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", 64'(bus.pc), 64'(RV));
        chk("rst_pc_valid", 64'(bus.pc_valid), 64'd1);
        reset_n = 1'b1;

        // Sequential fetch
        cyc(0, 1, NOP, 0, 0, 0, 0); chk("seq1", 64'(bus.pc), 64'h0BFC00004);
        cyc(0, 1, NOP, 0, 0, 0, 0); chk("seq2", 64'(bus.pc), 64'h0BFC00008);
        cyc(0, 1, NOP, 0, 0, 0, 0); chk("seq3", 64'(bus.pc), 64'h0BFC0000C);

        // BEQ taken backwards, then BNE not taken
        cyc(0, 1, NOP, 0, 0, 1, 32'hBFC00104);
        cyc(0, 1, {6'd4, 5'd1, 5'd2, 16'hFFFE}, 5, 5, 0, 0);
        chk("beq_pc", 64'(bus.pc), 64'h0BFC000FC);
        chk("beq_cb", 64'(bus.cnt_branch), 64'd1);
        chk("beq_ct", 64'(bus.cnt_taken), 64'd1);
        cyc(0, 1, {6'd5, 5'd1, 5'd2, 16'h0010}, 7, 7, 0, 0);
        chk("bne_pc", 64'(bus.pc), 64'h0BFC00100);
        chk("bne_cb", 64'(bus.cnt_branch), 64'd2);
        chk("bne_ct", 64'(bus.cnt_taken), 64'd1);

        // Misaligned JR
        cyc(0, 1, NOP, 0, 0, 1, 32'hBFC00010);
        cyc(0, 1, {6'd0, 5'd3, 15'd0, 6'd8}, 32'h8000_0002, 0, 0, 0);
        chk("jr_pc", 64'(bus.pc), 64'(EV));
        chk("jr_exc", 64'(bus.exc_valid), 64'd1);
        chk("jr_badv", 64'(bus.exc_badvaddr), 64'h080000002);
        chk("jr_epc", 64'(bus.exc_epc), 64'h0BFC0000C);
        cyc(0, 1, NOP, 0, 0, 0, 0);
        chk("jr_exc_pulse", 64'(bus.exc_valid), 64'd0);

        // Redirect buffered across a 4-cycle stall, applied with pc_write=0
        cyc(1, 1, NOP, 0, 0, 0, 0);           chk("st1", 64'(bus.pc), 64'h0BFC00384);
        cyc(1, 1, NOP, 0, 0, 1, 32'h1000);    chk("st2", 64'(bus.pc), 64'h0BFC00384);
        cyc(1, 1, NOP, 0, 0, 0, 0);           chk("st3", 64'(bus.pc), 64'h0BFC00384);
        cyc(1, 1, NOP, 0, 0, 0, 0);           chk("st4", 64'(bus.pc), 64'h0BFC00384);
        cyc(0, 0, NOP, 0, 0, 0, 0);           chk("st_apply", 64'(bus.pc), 64'h1000);

        // JR to HALT_ADDR, sit in HALT, then resume by redirect
        cyc(0, 1, {6'd0, 5'd3, 15'd0, 6'd8}, 32'h0, 0, 0, 0);
        chk("halt_pc", 64'(bus.pc), 64'h0);
        chk("halt_h", 64'(bus.halted), 64'd1);
        chk("halt_v", 64'(bus.pc_valid), 64'd0);
        for (int i = 0; i < 10; i++) cyc(0, 1, {6'd2, 26'h123}, 0, 0, 0, 0);
        chk("halt_hold", 64'(bus.pc), 64'h0);
        cyc(0, 1, NOP, 0, 0, 1, 32'h40);
        chk("resume_pc", 64'(bus.pc), 64'h40);
        chk("resume_h", 64'(bus.halted), 64'd0);

        // Async reset in the middle of a stall drops the buffered redirect
        cyc(1, 1, NOP, 0, 0, 1, 32'h2000);
        bus.ext_redirect_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1 chk("async_rst_pc", 64'(bus.pc), 64'(RV));
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc(0, 0, NOP, 0, 0, 0, 0);
        chk("rst_drop_pc", 64'(bus.pc), 64'(RV));

        // Simultaneous redirect and misaligned JR: redirect wins, no exception
        cyc(0, 1, {6'd0, 5'd3, 15'd0, 6'd9}, 32'h0000_0101, 0, 1, 32'h300);
        chk("rdr_jr_pc", 64'(bus.pc), 64'h300);
        chk("rdr_jr_exc", 64'(bus.exc_valid), 64'd0);
        chk("rdr_jr_badv", 64'(bus.exc_badvaddr), 64'd0);

        // Randomized traffic checked every cycle by the compare process
        for (int i = 0; i < 4000; i++) begin
            rs = rnd_val();
            rt = ($urandom_range(0, 2) == 0) ? rs : rnd_val();
            ra = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'hFFFF_FFFC);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0, rnd_instr(),
                rs, rt, $urandom_range(0, 19) == 0, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_pc_ctrl.md
# pipe_pc_ctrl

Parametrised program-counter controller for the pipelined MIPS core. It sits in IF and takes the instruction held in IF/ID plus forwarded register operands. It resolves branches, jumps and jump-registers in ID and drives the fetch address. Compared with the first-generation PC block it adds:
- configurable width and vectors;
- a precise misaligned-target exception in place of a simulation abort;
- a buffered external redirect that survives memory stalls;
- an explicit halt state;
- branch statistics counters.

## Interface
Parameters:
- `ADDR_W`, 32: PC and operand width.
- `RESET_VECTOR`, 32'hBFC00000: PC after reset.
- `EXC_VECTOR`, 32'hBFC00380: target on misaligned jump.
- `HALT_ADDR`, 0: reaching this PC enters HALT.
- `CNT_W`, 32: statistics counter width.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `waitrequest`  in  1  instruction memory stall; no PC update while high.
- `pc_write`  in  1  hazard-unit enable; 0 holds PC (ID stall).
- `id_instr`  in  32  instruction in IF/ID.
- `rs_val`, `rt_val`  in  ADDR_W  forwarded operands of `id_instr`.
- `ext_redirect_valid`  in  1  one-cycle request from a later stage.
- `ext_redirect_addr`  in  ADDR_W  redirect target.
- `pc`  out  ADDR_W  current fetch address.
- `pc_valid`  out  1  fetch request; 0 in HALT.
- `halted`  out  1  FSM in HALT.
- `exc_valid`  out  1  one-cycle pulse on misaligned jump.
- `exc_badvaddr`, `exc_epc`  out  ADDR_W  latched faulting target and jump PC.
- `cnt_branch`, `cnt_taken`  out  CNT_W  resolved conditional branches / taken ones.

## Operation
- Decode `id_instr`:
  - BEQ/BNE compare `rs_val` with `rt_val`.
  - REGIMM (BLTZ, BGEZ, BLTZAL, BGEZAL), BGTZ and BLEZ test the sign and zero of `rs_val`.
  - J/JAL use the region of `pc+4`.
  - JR/JALR (funct 001000/001001) use `rs_val`.
- Targets:
  - branch: `pc + sext(imm16<<2)`. `pc` is already the delay-slot address, which equals branch PC+4.
  - J/JAL: `{(pc+4)[ADDR_W-1:28], instr_index, 2'b00}`.
  - All arithmetic is modulo 2^ADDR_W.
- Next-PC priority: pending/external redirect > misaligned JR/JALR > taken branch > J/JAL > JR/JALR > `pc+4`.
- A JR/JALR target with `rs_val[1:0]≠0`:
  - `pc <= EXC_VECTOR`;
  - `exc_badvaddr <= rs_val`;
  - `exc_epc <= pc-4`;
  - `exc_valid` pulses.
- Redirect buffer: a `ext_redirect_valid` seen while `waitrequest=1` is latched. A later request overwrites it (last wins). The buffered target is applied at the first cycle with `waitrequest=0`, regardless of `pc_write`.
- FSM:
  - RUN → HALT when `pc==HALT_ADDR`. `pc` holds, `pc_valid=0`, `halted=1`.
  - HALT → RUN only on an applied external redirect.
  - Branch, jump and exception decode are ignored in HALT.
- Counters:
  - Counted on each applied update (`waitrequest=0`, `pc_write=1`, RUN) where `id_instr` is a conditional branch.
  - `cnt_branch` increments on every such branch; `cnt_taken` only when the branch is taken.
  - Counters wrap at 2^CNT_W.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert use):
  - `pc=RESET_VECTOR`, `pc_valid=1`, `halted=0`, `exc_valid=0`;
  - `exc_badvaddr=0`, `exc_epc=0`;
  - counters 0; redirect buffer empty; FSM RUN.
- Next-PC logic is combinational from `id_instr`, `rs_val` and `rt_val`. `pc` updates on the `clk` edge, so decision to fetch-address latency is 1 cycle.
- Update condition: `waitrequest=0` and (`pc_write=1` or redirect pending or redirect valid).
- `waitrequest=1` freezes `pc`, the counters and the FSM. Only the redirect buffer may load.
- Simultaneous redirect and misaligned JR: the redirect wins, there is no `exc_valid`, and `exc_*` registers hold.
- A redirect to `HALT_ADDR` enters HALT the following cycle.
- Reset asserted mid-stall clears the buffered redirect.

## Structure
- Shared package `pipe_pkg`:
  - opcode/funct/regimm constants (BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, REGIMM 000001, J 000010, JAL 000011);
  - FSM enum `pc_state_t {PC_RUN, PC_HALT}`.
- One sub-module, `pipe_branch_resolve`: combinational decode, compare and target selection, producing taken, target and misalign.

## Test plan
- Reset release: `pc=BFC00000`; 3 cycles with `pc_write=1` and a NOP give `pc` BFC00004, BFC00008, BFC0000C.
- BEQ with `rs=rt=5` and imm=-2 at `pc=BFC00104`: next `pc=BFC000FC`, `cnt_branch=1`, `cnt_taken=1`. BNE with `rs=rt`: `pc+4`, `cnt_taken` unchanged.
- JR with `rs_val=0x8000_0002` at `pc=BFC00010`: `pc=BFC00380`, `exc_valid` for exactly 1 cycle, `exc_badvaddr=80000002`, `exc_epc=BFC0000C`.
- `waitrequest=1` for 4 cycles with `ext_redirect` to `0x1000` pulsed in cycle 2: `pc` holds until `waitrequest` falls, then `pc=0x1000` on the next edge, even with `pc_write=0`.
- JR to 0: next `pc=0`, `halted=1`, `pc_valid=0`; the PC stays at 0 for 10 cycles; `ext_redirect` to `0x40` resumes RUN with `pc=0x40`.
- `reset_n` asserted mid-stall with a buffered redirect: immediate `pc=BFC00000` with no clock edge; after release the buffered redirect is not applied.
